// File: rtl/antsel_pkg.sv
// Shared types and width helpers for the antenna power selector.
// Holds the FSM state encoding and accumulator/index width derivations.
// No logic; imported by the selector and its saturating adder.
package antsel_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int clog2_w(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int ant_w(input int num_ant);
        return clog2_w(num_ant);
    endfunction

    // Guard bits let a full frame of max-valued samples sum without wrapping.
    function automatic int acc_w(input int data_width, input int num_sc);
        return 2 * data_width + clog2_w(num_sc);
    endfunction

endpackage

// File: rtl/antenna_power_select_sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags overflow.
// Latency: combinational.
// Backpressure: none.
module sat_add #(
    parameter int A_W = 22,
    parameter int B_W = 16
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           ovf
);

    logic [A_W:0] full;

    assign full = {1'b0, a} + (A_W+1)'(b);
    assign ovf  = full[A_W];
    assign sum  = ovf ? '1 : full[A_W-1:0];

endmodule

// File: rtl/antenna_power_select.sv
// Accumulates |h|^2 per antenna over a frame, then picks the strongest antenna by sequential argmax.
// Latency: result valid NUM_ANT+1 cycles after the in_last handshake.
// Backpressure: in_ready low outside ACCUM; result held in OUT until out_ready.
module antenna_power_select
    import antsel_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_ANT    = 4,
    parameter int  NUM_SC     = 64,
    localparam int ANT_W      = ant_w(NUM_ANT),
    localparam int ACC_W      = acc_w(DATA_WIDTH, NUM_SC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_mag,
    input  logic [ANT_W-1:0]        in_ant,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ANT_W-1:0]        out_ant_idx,
    output logic [ACC_W-1:0]        out_power,
    output logic                    out_err
);

    localparam logic [ANT_W:0]   NUM_ANT_V = (ANT_W+1)'(NUM_ANT);
    localparam logic [ANT_W-1:0] LAST_IDX  = ANT_W'(NUM_ANT - 1);

    state_t           state;
    logic [ACC_W-1:0] acc [NUM_ANT];
    logic             err;
    logic [ANT_W-1:0] scan_idx;
    logic [ANT_W-1:0] best_idx;
    logic [ACC_W-1:0] best_pow;

    logic             in_hs;
    logic             tag_ok;
    logic [ANT_W-1:0] upd_idx;
    logic [ACC_W-1:0] upd_sum;
    logic             upd_ovf;
    logic             scan_take;
    logic [ANT_W-1:0] nxt_idx;
    logic [ACC_W-1:0] nxt_pow;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign in_hs     = in_valid & in_ready;

    // Out-of-range tags (possible when NUM_ANT is not a power of two) are steered to a legal index and never written.
    assign tag_ok  = ({1'b0, in_ant} < NUM_ANT_V);
    assign upd_idx = tag_ok ? in_ant : '0;

    sat_add #(
        .A_W (ACC_W),
        .B_W (2*DATA_WIDTH)
    ) u_sat_add (
        .a   (acc[upd_idx]),
        .b   (in_mag),
        .sum (upd_sum),
        .ovf (upd_ovf)
    );

    // Strict greater-than keeps the earlier index on ties.
    assign scan_take = (scan_idx == '0) || (acc[scan_idx] > best_pow);
    assign nxt_idx   = scan_take ? scan_idx : best_idx;
    assign nxt_pow   = scan_take ? acc[scan_idx] : best_pow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            for (int i = 0; i < NUM_ANT; i++) acc[i] <= '0;
            err         <= 1'b0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best_pow    <= '0;
            out_ant_idx <= '0;
            out_power   <= '0;
            out_err     <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    for (int i = 0; i < NUM_ANT; i++) acc[i] <= '0;
                    err      <= 1'b0;
                    scan_idx <= '0;
                    state    <= ACCUM;
                end
                ACCUM: begin
                    if (in_hs) begin
                        if (tag_ok) begin
                            acc[upd_idx] <= upd_sum;
                            if (upd_ovf) err <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        if (in_last) begin
                            scan_idx <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    best_idx <= nxt_idx;
                    best_pow <= nxt_pow;
                    scan_idx <= scan_idx + ANT_W'(1);
                    if (scan_idx == LAST_IDX) begin
                        out_ant_idx <= nxt_idx;
                        out_power   <= nxt_pow;
                        out_err     <= err;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) state <= CLEAR;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
